// File: rtl/mul_seq32_pkg.sv
// Shared definitions for the sequential 32x32 shift-add multiplier.
package mul_seq32_pkg;

    localparam int         WIDTH_DEF = 32;
    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_seq32_csa32.sv
// 32-bit carry-select adder: the low half ripples, and the high half is
// precomputed for both carry-in values and picked by the low-half carry.
module csa32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    logic [16:0] lo_s;
    logic [16:0] hi_s0;
    logic [16:0] hi_s1;

    assign lo_s  = {1'b0, a[15:0]}  + {1'b0, b[15:0]}  + {16'b0, c_in};
    assign hi_s0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign hi_s1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

    assign sum   = {(lo_s[16] ? hi_s1[15:0] : hi_s0[15:0]), lo_s[15:0]};
    assign c_out = lo_s[16] ? hi_s1[16] : hi_s0[16];

endmodule

// File: rtl/mul_seq32.sv
// Sequential multiplier: magnitudes are multiplied by 32 shift-add steps,
// then the 64-bit result is negated once if the operand signs differed.
// Latency from accept to out_valid is a fixed 33 cycles.
module mul_seq32
    import mul_seq32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             busy
);

    localparam logic [WIDTH-1:0]   ONE  = 1;
    localparam logic [2*WIDTH-1:0] ONE2 = 1;

    state_t           state, state_nxt;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] acc_hi, lo, mag_a;
    logic             neg;

    logic [WIDTH-1:0]   mag_in_a, mag_in_b, addend, sum;
    logic               cout;
    logic [2*WIDTH-1:0] prod_neg;

    // Unsigned magnitudes; -2^31 maps to 0x8000_0000 without overflow.
    assign mag_in_a = (op_signed && a[WIDTH-1]) ? (~a + ONE) : a;
    assign mag_in_b = (op_signed && b[WIDTH-1]) ? (~b + ONE) : b;

    assign addend   = lo[0] ? mag_a : '0;
    assign prod_neg = ~{acc_hi, lo} + ONE2;

    csa32 u_add (
        .a     (acc_hi),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (cout)
    );

    assign prod_hi = acc_hi;
    assign prod_lo = lo;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: if (cnt == ITER_LAST) state_nxt = NEG;
            NEG:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, one shift-add per BUSY cycle, sign fixup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            lo     <= '0;
            mag_a  <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mag_a  <= mag_in_a;
                    lo     <= mag_in_b;
                    acc_hi <= '0;
                    cnt    <= '0;
                    neg    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                end
                BUSY: begin
                    // Carry-out lands in the top bit so the product stays exact.
                    {acc_hi, lo} <= {cout, sum, lo[WIDTH-1:1]};
                    cnt          <= cnt + 5'd1;
                end
                NEG: if (neg) {acc_hi, lo} <= prod_neg;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_seq32.md
MUL_SEQ32 -- requirements
Module: mul_seq32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, operands and op_signed are valid.
REQ-005 The block SHALL have port in_ready, output, 1, block accepts a new operation.
REQ-006 The block SHALL have port a, input, 32, multiplicand.
REQ-007 The block SHALL have port b, input, 32, multiplier.
REQ-008 The block SHALL have port op_signed, input, 1, 1 = two's-complement operands, 0 = unsigned.
REQ-009 The block SHALL have port out_valid, output, 1, product is valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer takes the product.
REQ-011 The block SHALL have port prod_hi, output, 32, product bits 63:32.
REQ-012 The block SHALL have port prod_lo, output, 32, product bits 31:0.
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, NEG and DONE.
REQ-015 in_ready SHALL equal (state==IDLE); acceptance SHALL occur on an edge where in_valid && in_ready.
REQ-016 On acceptance the block SHALL latch |a| and |b| (magnitudes if op_signed, else raw), latch neg = op_signed && (a[31]^b[31]), clear acc_hi, load lo = |b|, clear cnt, and go to BUSY.
REQ-017 Each BUSY edge SHALL perform one iteration: sum = acc_hi + (lo[0] ? |a| : 0) through the 32-bit adder with c_in=0, then {acc_hi,lo} <= {cout,sum,lo} >> 1.
REQ-018 cnt SHALL be 5 bits, incrementing each BUSY edge; BUSY SHALL go to NEG on the edge with cnt==31, so there are exactly 32 iterations.
REQ-019 NEG SHALL last one cycle: {acc_hi,lo} <= neg ? (~{acc_hi,lo} + 1) : {acc_hi,lo}; then go to DONE.
REQ-020 Latency SHALL be fixed: out_valid SHALL rise exactly 33 cycles after the accepting edge, independent of operand values. There is no early exit for zero operands.
REQ-021 In DONE, out_valid SHALL be 1, and prod_hi/prod_lo SHALL show the register contents and stay stable while out_ready=0.
REQ-022 DONE SHALL go to IDLE on the edge where out_ready=1; in_ready SHALL rise in the following cycle, so there is no same-cycle accept in DONE.
REQ-023 in_valid, a, b and op_signed SHALL be ignored in every state except IDLE.
REQ-024 Signed magnitudes SHALL be computed as unsigned 32-bit values, so -2^31 becomes 0x8000_0000 with no overflow.
REQ-025 The unsigned product SHALL be exact over 64 bits; the adder carry-out SHALL never be dropped.
REQ-026 prod_hi/prod_lo SHALL be undefined-but-stable outside DONE; the verifier SHALL sample them only when out_valid=1.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, cnt=0, acc_hi=0, lo=0, neg=0, out_valid=0, busy=0, prod_hi=prod_lo=0; in_ready SHALL then be 1.
REQ-028 Reset asserted during BUSY/NEG/DONE SHALL abort the operation, and no out_valid SHALL follow.
REQ-029 Reset deassertion SHALL be synchronised by the integrator; the block only requires rst_n to be glitch-free.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, BUSY, NEG, DONE), the WIDTH default and ITER_LAST=31.
REQ-031 The per-iteration add SHALL use one instance of the team's 32-bit carry-select adder CSA32 (c_in tied 0), with cout taken from its bit-31 carry.
REQ-032 Negation and magnitude conversion SHALL be local combinational logic, with no second adder instance required.

Verification
REQ-033 Scenario 1: unsigned a=7, b=6 -> prod = 0x00000000_0000002A, with out_valid 33 cycles after accept.
REQ-034 Scenario 2: unsigned a=b=0xFFFFFFFF -> prod = 0xFFFFFFFE_00000001.
REQ-035 Scenario 3: signed a=0xFFFFFFFD (-3), b=5 -> prod = 0xFFFFFFFF_FFFFFFF1; signed a=b=0x80000000 -> prod = 0x40000000_00000000.
REQ-036 Scenario 4: hold out_ready=0 for 10 cycles in DONE -> out_valid and prod stay constant, in_ready stays 0, and a pulse of in_valid with new operands is ignored.
REQ-037 Scenario 5: assert rst_n=0 at iteration 15, then release -> in_ready=1 and busy=0 immediately, no out_valid; the next op 3*4 yields 12.
REQ-038 Scenario 6: issue back-to-back ops with out_ready tied 1 -> accept-to-accept spacing of 35 cycles, and 1000 random signed/unsigned pairs match the reference model.
